// File: rtl/result_pkg.sv
// Shared constants and types for the result collector slice.
//   DATA_W    : width of one unsigned ALU result
//   N_RESULTS : results per job (8 columns x 4 rows)
//   ADDR_W    : index width for storage and streamed addresses
package result_pkg;

  localparam int unsigned DATA_W    = 19;
  localparam int unsigned N_RESULTS = 32;
  localparam int unsigned ADDR_W    = $clog2(N_RESULTS);

  typedef logic [DATA_W-1:0] result_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t LastAddr = addr_t'(N_RESULTS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StReadout,
    StDone
  } state_e;

endpackage

// File: rtl/result_collector_if.sv
// Handshake bundle between the collector and its neighbours.
//   res_valid/res_data/res_ready : ALU result input channel
//   out_valid/out_data/out_addr/out_ready : stored-result output stream
// master: the environment (ALU producer and output consumer).
// slave : the collector itself.
interface result_collector_if;
  import result_pkg::*;

  logic    res_valid;
  result_t res_data;
  logic    res_ready;
  logic    out_valid;
  logic    out_ready;
  result_t out_data;
  addr_t   out_addr;

  modport master (
    output res_valid, res_data, out_ready,
    input  res_ready, out_valid, out_data, out_addr
  );

  modport slave (
    input  res_valid, res_data, out_ready,
    output res_ready, out_valid, out_data, out_addr
  );

endinterface

// File: rtl/result_mem.sv
// N_RESULTS x DATA_W register array with one write port and one synchronous,
// enable-gated read port. Contents are not reset; only the read register is,
// so the streamed data output starts at zero.
//   clk, rst        : clock, async active-low reset (read register only)
//   we/waddr/wdata  : write port
//   re/raddr        : read request; rdata updates on the next edge when re=1
//   rdata           : registered read data, held while re=0
module result_mem
  import result_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    we,
  input  addr_t   waddr,
  input  result_t wdata,
  input  logic    re,
  input  addr_t   raddr,
  output result_t rdata
);

  result_t mem_q [N_RESULTS];
  result_t rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/result_collector.sv
// Collects one job of N_RESULTS ALU results, tracks the running maximum, then
// streams the stored results out in index order under valid/ready.
//   clk, rst     : clock, async active-low reset
//   start        : one-cycle pulse starting a job (ignored mid-job)
//   bus          : result input channel and output stream (slave side)
//   max_val      : largest result of the job (first occurrence wins ties)
//   max_addr     : index of max_val
//   collect_done : one-cycle pulse after the last result is stored
//   finish       : level, job fully streamed, held until the next start
module result_collector
  import result_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  result_collector_if.slave   bus,
  output result_t             max_val,
  output addr_t               max_addr,
  output logic                collect_done,
  output logic                finish
);

  state_e  state_q, state_d;
  addr_t   wr_ptr_q, wr_ptr_d;
  addr_t   rd_ptr_q, rd_ptr_d;
  result_t max_val_q, max_val_d;
  addr_t   max_addr_q, max_addr_d;
  logic    collect_done_q, collect_done_d;
  logic    finish_q, finish_d;
  logic    out_valid_q, out_valid_d;
  addr_t   out_addr_q, out_addr_d;

  logic    res_ready;
  logic    accept;
  logic    mem_we;
  logic    mem_re;
  result_t mem_rdata;

  assign res_ready = (state_q == StCollect);
  assign accept    = bus.res_valid & res_ready;

  result_mem u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (bus.res_data),
    .re    (mem_re),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    max_val_d      = max_val_q;
    max_addr_d     = max_addr_q;
    collect_done_d = 1'b0;
    finish_d       = finish_q;
    out_valid_d    = out_valid_q;
    out_addr_d     = out_addr_q;
    mem_we         = 1'b0;
    mem_re         = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StCollect;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          max_val_d  = '0;
          max_addr_d = '0;
          finish_d   = 1'b0;
        end
      end

      StCollect: begin
        if (accept) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + addr_t'(1);
          // Strictly greater keeps the earliest index on ties.
          if (bus.res_data > max_val_q) begin
            max_val_d  = bus.res_data;
            max_addr_d = wr_ptr_q;
          end
          if (wr_ptr_q == LastAddr) begin
            state_d        = StReadout;
            collect_done_d = 1'b1;
            rd_ptr_d       = '0;
          end
        end
      end

      StReadout: begin
        // The read register doubles as the output register: it reloads
        // whenever it is empty or being consumed, giving zero-bubble streaming.
        if (!out_valid_q || bus.out_ready) begin
          if (out_valid_q && (out_addr_q == LastAddr)) begin
            state_d     = StDone;
            out_valid_d = 1'b0;
            finish_d    = 1'b1;
          end else begin
            mem_re      = 1'b1;
            out_valid_d = 1'b1;
            out_addr_d  = rd_ptr_q;
            rd_ptr_d    = rd_ptr_q + addr_t'(1);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      max_val_q      <= '0;
      max_addr_q     <= '0;
      collect_done_q <= 1'b0;
      finish_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      out_addr_q     <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      max_val_q      <= max_val_d;
      max_addr_q     <= max_addr_d;
      collect_done_q <= collect_done_d;
      finish_q       <= finish_d;
      out_valid_q    <= out_valid_d;
      out_addr_q     <= out_addr_d;
    end
  end

  assign bus.res_ready = res_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = mem_rdata;
  assign bus.out_addr  = out_addr_q;
  assign max_val       = max_val_q;
  assign max_addr      = max_addr_q;
  assign collect_done  = collect_done_q;
  assign finish        = finish_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: a table of whole jobs (data pattern,
// gaps, backpressure, ignored-input pokes, expected max) plus a mid-job reset
// sequence. Inputs are driven and outputs sampled on the falling edge.
module tb_result_collector;
  import result_pkg::*;

  typedef struct {
    int          kind;
    bit          gaps;
    bit          bp;
    bit          ign;
    logic [18:0] exp_max;
    logic [4:0]  exp_addr;
  } vec_t;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  logic    start = 1'b0;
  result_t max_val;
  addr_t   max_addr;
  logic    collect_done;
  logic    finish;

  int tests = 0;
  int fails = 0;

  result_collector_if bus ();

  result_collector dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .max_val      (max_val),
    .max_addr     (max_addr),
    .collect_done (collect_done),
    .finish       (finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic result_t gen(input int kind, input int i);
    case (kind)
      0: return result_t'(i);
      1: return (i == 3) ? result_t'(5) : ((i == 7 || i == 20) ? result_t'(9) : result_t'(0));
      2: return (i == 31) ? result_t'(524287) : result_t'(100);
      3: return result_t'(31 - i);
      5: return result_t'(1000 + i);
      default: return result_t'(0);
    endcase
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input string tag);
    result_t exp_data [N_RESULTS];
    int idx;
    int cyc;
    bit prev_hs;
    bit rdy;
    logic [3:0] bp_pat;
    bp_pat = 4'b1001;  // out_ready sequence 1,0,0,1 (bit 0 first)

    pulse_start();
    chk({tag, " finish_cleared"}, finish, 0);
    chk({tag, " max_cleared"}, max_val, 0);
    chk({tag, " res_ready_collect"}, bus.res_ready, 1);

    for (int i = 0; i < N_RESULTS; i++) begin
      if (v.gaps && $urandom_range(0, 2) == 0) begin
        bus.res_valid = 1'b0;
        bus.res_data  = '1;
        @(negedge clk);
        chk({tag, " gap_no_done"}, collect_done, 0);
      end
      exp_data[i]   = gen(v.kind, i);
      bus.res_valid = 1'b1;
      bus.res_data  = exp_data[i];
      if (v.ign && i == 10) start = 1'b1;
      if (bus.res_ready !== 1'b1) chk({tag, " res_ready_during_collect"}, bus.res_ready, 1);
      if (collect_done !== 1'b0) chk({tag, " early_collect_done"}, collect_done, 0);
      @(negedge clk);
      start = 1'b0;
    end
    bus.res_valid = 1'b0;

    // One cycle after the last accept.
    chk({tag, " collect_done"}, collect_done, 1);
    chk({tag, " res_ready_readout"}, bus.res_ready, 0);
    chk({tag, " out_valid_latency0"}, bus.out_valid, 0);
    chk({tag, " max_val"}, max_val, v.exp_max);
    chk({tag, " max_addr"}, max_addr, v.exp_addr);
    @(negedge clk);
    chk({tag, " collect_done_pulse"}, collect_done, 0);
    chk({tag, " out_valid_latency1"}, bus.out_valid, 1);

    idx = 0;
    cyc = 0;
    prev_hs = 1'b0;
    while (idx < N_RESULTS && cyc < 400) begin
      if (bus.out_valid) begin
        if (bus.out_data !== exp_data[idx])
          chk($sformatf("%s out_data[%0d]", tag, idx), bus.out_data, exp_data[idx]);
        else tests++;
        if (bus.out_addr !== addr_t'(idx))
          chk($sformatf("%s out_addr[%0d]", tag, idx), bus.out_addr, idx);
        else tests++;
      end else if (prev_hs) begin
        chk($sformatf("%s bubble_before[%0d]", tag, idx), bus.out_valid, 1);
      end
      rdy = v.bp ? bp_pat[cyc % 4] : 1'b1;
      bus.out_ready = rdy;
      start = (v.ign && cyc == 3);
      prev_hs = bus.out_valid & rdy;
      if (prev_hs) idx++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    bus.out_ready = 1'b0;
    if (idx < N_RESULTS) chk({tag, " readout_timeout"}, idx, N_RESULTS);

    chk({tag, " finish"}, finish, 1);
    chk({tag, " out_valid_done"}, bus.out_valid, 0);
    chk({tag, " max_val_held"}, max_val, v.exp_max);
    chk({tag, " max_addr_held"}, max_addr, v.exp_addr);

    if (v.ign) begin
      bus.res_valid = 1'b1;
      bus.res_data  = 19'd77;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        chk({tag, " res_ready_done"}, bus.res_ready, 0);
        @(negedge clk);
      end
      bus.res_valid = 1'b0;
      bus.out_ready = 1'b0;
      chk({tag, " finish_still"}, finish, 1);
      chk({tag, " out_valid_still0"}, bus.out_valid, 0);
      chk({tag, " max_val_still"}, max_val, v.exp_max);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{kind: 0, gaps: 0, bp: 0, ign: 0, exp_max: 19'd31,     exp_addr: 5'd31};
    vecs[1] = '{kind: 0, gaps: 0, bp: 1, ign: 0, exp_max: 19'd31,     exp_addr: 5'd31};
    vecs[2] = '{kind: 1, gaps: 1, bp: 0, ign: 0, exp_max: 19'd9,      exp_addr: 5'd7};
    vecs[3] = '{kind: 2, gaps: 0, bp: 0, ign: 0, exp_max: 19'd524287, exp_addr: 5'd31};
    vecs[4] = '{kind: 3, gaps: 0, bp: 1, ign: 1, exp_max: 19'd31,     exp_addr: 5'd0};
    vecs[5] = '{kind: 4, gaps: 1, bp: 1, ign: 0, exp_max: 19'd0,      exp_addr: 5'd0};

    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst max_val", max_val, 0);
    chk("rst max_addr", max_addr, 0);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_data", bus.out_data, 0);
    chk("rst out_addr", bus.out_addr, 0);
    chk("rst collect_done", collect_done, 0);
    chk("rst finish", finish, 0);
    chk("rst res_ready", bus.res_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle res_ready", bus.res_ready, 0);

    for (int j = 0; j < 6; j++) begin
      run_job(vecs[j], $sformatf("job%0d", j));
      repeat (2) @(negedge clk);
    end

    // Mid-job reset after 12 accepts.
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      bus.res_valid = 1'b1;
      bus.res_data  = gen(5, i);
      @(negedge clk);
    end
    bus.res_valid = 1'b0;
    chk("midrst max_before", max_val, 1011);
    chk("midrst addr_before", max_addr, 11);
    rst = 1'b0;
    #1;
    chk("midrst max_val", max_val, 0);
    chk("midrst max_addr", max_addr, 0);
    chk("midrst res_ready", bus.res_ready, 0);
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst finish", finish, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst idle_res_ready", bus.res_ready, 0);
    run_job(vecs[4], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Downstream stage of the matrix-multiply datapath: captures each product emitted by the ALU, stores all results of one job, tracks the running maximum, then streams stored results out under a valid/ready handshake.
- Sits between the arithmetic unit's result port and the chip output / verification interface. Its `start` is raised by the top controller together with the job start.

Parameters:
- DATA_W, 19, width of one ALU result (unsigned).
- N_RESULTS, 32, results per job (8 columns x 4 rows).
- ADDR_W, 5, clog2(N_RESULTS); index width for storage and `out_addr`.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse that begins a new job (collection phase).
- res_valid  in  1  ALU result present on `res_data`.
- res_data  in  DATA_W  ALU result.
- res_ready  out  1  collector accepts a result this cycle.
- out_valid  out  1  `out_data`/`out_addr` hold a stored result.
- out_ready  in  1  consumer accepts the current output.
- out_data  out  DATA_W  stored result being streamed.
- out_addr  out  ADDR_W  index of `out_data` (0..N_RESULTS-1).
- max_val  out  DATA_W  largest result of the job.
- max_addr  out  ADDR_W  index of the first occurrence of `max_val`.
- collect_done  out  1  one-cycle pulse when the last result has been stored.
- finish  out  1  level: job fully streamed out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; write and read pointers = 0.
  - All outputs 0; memory contents don't-care.
- States: IDLE, COLLECT, READOUT, DONE.
- IDLE / DONE:
  - `res_ready`=0 and `out_valid`=0.
  - `start`=1 -> COLLECT next cycle; wr_ptr=0, max_val=0, max_addr=0, finish=0.
- COLLECT:
  - `res_ready`=1. Accept occurs when res_valid & res_ready.
  - On accept: mem[wr_ptr] <= res_data, wr_ptr++.
  - If res_data > max_val (unsigned, strictly greater): max_val <= res_data, max_addr <= wr_ptr. On ties the earlier index is kept.
  - The first accepted result always updates max, except when it is 0 (max stays 0, addr 0).
  - Gaps in `res_valid` are allowed; nothing changes on idle cycles.
  - Accept at wr_ptr=N_RESULTS-1 -> next cycle: state=READOUT, `collect_done`=1 for exactly that cycle, `res_ready`=0. wr_ptr wraps to 0.
- READOUT:
  - rd_ptr starts at 0. Memory read is synchronous, so `out_valid` rises 1 cycle after entering READOUT (2 cycles after the last accept).
  - `out_data`=mem[rd_ptr] and `out_addr`=rd_ptr, registered.
  - While out_valid & !out_ready, `out_data`/`out_addr` are held stable.
  - On out_valid & out_ready: the next entry is presented on the following cycle with no bubble. Prefetch with one-deep skid is permitted; only zero-bubble throughput is required.
  - Handshake on index N_RESULTS-1 -> DONE next cycle; out_valid=0, finish=1.
- DONE:
  - `finish` is held at 1 until the next `start`.
  - `max_val`/`max_addr` are held from `collect_done` until the next `start`.
- `start` while in COLLECT or READOUT is ignored. There is no mid-job restart; only `rst` aborts a job.
- `res_valid` outside COLLECT is ignored (res_ready=0). No overflow is possible because acceptance stops at N_RESULTS.
- Reset mid-operation returns to IDLE immediately. Partial data is discarded and is not streamed.
- `out_ready` outside READOUT has no effect.

Decomposition:
- Package `result_pkg`:
  - DATA_W, N_RESULTS, ADDR_W constants.
  - State enum typedef (IDLE, COLLECT, READOUT, DONE).
  - `result_t` = logic [DATA_W-1:0].
- Sub-module `result_mem`: N_RESULTS x DATA_W register array, 1 write port, 1 synchronous read port, no reset on contents.
- The FSM, pointers, max tracker and output registers stay in `result_collector`.

Test Plan:
- Basic job: start, feed 0..31 back-to-back, out_ready=1.
  - collect_done pulses 1 cycle after the 32nd accept.
  - Outputs stream 0..31 with addr 0..31, one per cycle.
  - max_val=31, max_addr=31; finish=1 after the last handshake.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly.
  - out_data/out_addr stay stable while stalled.
  - No entry is skipped or duplicated; all 32 are received in order.
- Max ties and gaps: feed 5 at idx 3, 9 at idx 7, 9 at idx 20, zeros elsewhere, with random res_valid gaps.
  - max_val=9, max_addr=7; exactly 32 accepts.
- Full-scale value: idx 31 = 2^19-1 (524287), others 100 -> max_val=524287, max_addr=31.
- Ignored inputs: start pulse during COLLECT at accept 10 and during READOUT; res_valid=1 in DONE.
  - No restart; counts unchanged; res_ready=0 outside COLLECT.
- Reset mid-job: rst=0 after 12 accepts.
  - All outputs 0 immediately; state IDLE.
  - A fresh start plus 32 results completes normally with the new values only.
